// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch FSM state encoding, PC arithmetic constants
// and the reset vector used across the core.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] FETCH_PC_STEP    = 32'd4;
  localparam logic [31:0] FETCH_PC_AHEAD   = 32'd8;
  localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with hold / sequential / redirect next-pc selection
// and the read-ahead adder that produces the R15 value for decode.
module fetch_pc_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_STEP  = FETCH_PC_STEP,
  parameter logic [31:0] PC_AHEAD = FETCH_PC_AHEAD
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        pc_inc,
  input  logic        pc_redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic [31:0] pc_ahead
);

  logic [31:0] pc_next;

  // A redirect always wins over the sequential step so a squashed fetch can
  // never advance the PC past the branch target.
  always_comb begin
    pc_next = pc;
    if (pc_redirect) begin
      pc_next = align_word(redirect_target);
    end else if (pc_inc) begin
      pc_next = pc + PC_STEP;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  assign pc_ahead = pc + PC_AHEAD;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding instruction memory request,
// registered output word with valid/ready to decode, and branch redirect squash.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_STEP  = FETCH_PC_STEP,
  parameter logic [31:0] PC_AHEAD = FETCH_PC_AHEAD
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC,
  output logic [31:0] R15
);

  fetch_state_t state;
  logic         discard;
  logic [31:0]  pc;
  logic [31:0]  pc_ahead;
  logic         capture;

  // A returned word is only kept when it belongs to the current PC stream.
  assign capture = (state == ST_WAIT) && IMEM_RVALID && !discard && !BR_TAKEN;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP),
    .PC_AHEAD (PC_AHEAD)
  ) u_pc_reg (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .pc_inc          (capture),
    .pc_redirect     (BR_TAKEN),
    .redirect_target (BR_TARGET),
    .pc              (pc),
    .pc_ahead        (pc_ahead)
  );

  assign IMEM_ADDR = pc;

  // Moore FSM with all handshake and output-register state updated together;
  // BR_TAKEN is tested first in every state so a redirect overrides all else.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      discard     <= 1'b0;
      IMEM_REQ    <= 1'b0;
      INSTR_VALID <= 1'b0;
      INSTR       <= 32'h0;
      INSTR_PC    <= RESET_PC;
      R15         <= RESET_PC + PC_AHEAD;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_REQ;
          IMEM_REQ <= 1'b1;
        end

        ST_REQ: begin
          if (BR_TAKEN) begin
            if (IMEM_GNT) begin
              discard  <= 1'b1;
              IMEM_REQ <= 1'b0;
              state    <= ST_WAIT;
            end
          end else if (IMEM_GNT) begin
            IMEM_REQ <= 1'b0;
            state    <= ST_WAIT;
          end
        end

        // The word for an already-accepted request must still be drained,
        // so a redirect here either drops it now or marks it for dropping.
        ST_WAIT: begin
          if (BR_TAKEN) begin
            if (IMEM_RVALID) begin
              discard  <= 1'b0;
              IMEM_REQ <= 1'b1;
              state    <= ST_REQ;
            end else begin
              discard <= 1'b1;
            end
          end else if (IMEM_RVALID) begin
            if (discard) begin
              discard  <= 1'b0;
              IMEM_REQ <= 1'b1;
              state    <= ST_REQ;
            end else begin
              INSTR       <= IMEM_RDATA;
              INSTR_PC    <= pc;
              R15         <= pc_ahead;
              INSTR_VALID <= 1'b1;
              state       <= ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (BR_TAKEN || INSTR_READY) begin
            INSTR_VALID <= 1'b0;
            IMEM_REQ    <= 1'b1;
            state       <= ST_REQ;
          end
        end

        default: begin
          state       <= ST_IDLE;
          discard     <= 1'b0;
          IMEM_REQ    <= 1'b0;
          INSTR_VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stalls, redirects and
// a wrapping reset vector on a second instance.
module tb_fetch_stage;

  logic        CLK;
  logic        RESET_N;
  logic        IMEM_GNT;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic        BR_TAKEN;
  logic [31:0] BR_TARGET;
  logic        INSTR_READY;

  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        INSTR_VALID;
  logic [31:0] INSTR;
  logic [31:0] INSTR_PC;
  logic [31:0] R15;

  logic        d1_imem_req;
  logic [31:0] d1_imem_addr;
  logic        d1_instr_valid;
  logic [31:0] d1_instr;
  logic [31:0] d1_instr_pc;
  logic [31:0] d1_r15;

  int check_count = 0;
  int fail_count  = 0;

  fetch_stage dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .IMEM_REQ    (IMEM_REQ),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_GNT    (IMEM_GNT),
    .IMEM_RVALID (IMEM_RVALID),
    .IMEM_RDATA  (IMEM_RDATA),
    .BR_TAKEN    (BR_TAKEN),
    .BR_TARGET   (BR_TARGET),
    .INSTR_VALID (INSTR_VALID),
    .INSTR_READY (INSTR_READY),
    .INSTR       (INSTR),
    .INSTR_PC    (INSTR_PC),
    .R15         (R15)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .IMEM_REQ    (d1_imem_req),
    .IMEM_ADDR   (d1_imem_addr),
    .IMEM_GNT    (IMEM_GNT),
    .IMEM_RVALID (IMEM_RVALID),
    .IMEM_RDATA  (IMEM_RDATA),
    .BR_TAKEN    (BR_TAKEN),
    .BR_TARGET   (BR_TARGET),
    .INSTR_VALID (d1_instr_valid),
    .INSTR_READY (INSTR_READY),
    .INSTR       (d1_instr),
    .INSTR_PC    (d1_instr_pc),
    .R15         (d1_r15)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                               input logic ready, input logic br, input logic [31:0] target);
    IMEM_GNT    = gnt;
    IMEM_RVALID = rvalid;
    IMEM_RDATA  = rdata;
    INSTR_READY = ready;
    BR_TAKEN    = br;
    BR_TARGET   = target;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Starts in REQ at pc_exp with single-cycle GNT, RVALID and READY.
  task automatic doFetch(input string tag, input logic [31:0] data, input logic [31:0] pc_exp);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    checkOutput({tag, "_req_drop"}, {31'h0, IMEM_REQ}, 32'h0);
    applyStimulus(1'b0, 1'b1, data, 1'b0, 1'b0, 32'h0);
    step();
    checkOutput({tag, "_valid"}, {31'h0, INSTR_VALID}, 32'h1);
    checkOutput({tag, "_instr"}, INSTR, data);
    checkOutput({tag, "_pc"}, INSTR_PC, pc_exp);
    checkOutput({tag, "_r15"}, R15, pc_exp + 32'd8);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    checkOutput({tag, "_consumed"}, {31'h0, INSTR_VALID}, 32'h0);
    checkOutput({tag, "_rereq"}, {31'h0, IMEM_REQ}, 32'h1);
    checkOutput({tag, "_next_addr"}, IMEM_ADDR, pc_exp + 32'd4);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    RESET_N = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (3) step();

    checkOutput("rst_req", {31'h0, IMEM_REQ}, 32'h0);
    checkOutput("rst_addr", IMEM_ADDR, 32'h0);
    checkOutput("rst_valid", {31'h0, INSTR_VALID}, 32'h0);
    checkOutput("rst_instr", INSTR, 32'h0);
    checkOutput("rst_instr_pc", INSTR_PC, 32'h0);
    checkOutput("rst_r15", R15, 32'h8);
    checkOutput("rst_wrap_addr", d1_imem_addr, 32'hFFFF_FFFC);
    checkOutput("rst_wrap_r15", d1_r15, 32'h0000_0004);

    RESET_N = 1'b1;
    step();
    checkOutput("idle_to_req", {31'h0, IMEM_REQ}, 32'h1);
    checkOutput("first_addr", IMEM_ADDR, 32'h0);

    $display("[TB] sequential fetch");
    doFetch("seq0", 32'hE000_00A0, 32'h0);
    doFetch("seq1", 32'hE000_00A4, 32'h4);
    doFetch("seq2", 32'hE000_00A8, 32'h8);

    $display("[TB] grant stall");
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("stall_req", {31'h0, IMEM_REQ}, 32'h1);
      checkOutput("stall_addr", IMEM_ADDR, 32'hC);
      checkOutput("stall_novalid", {31'h0, INSTR_VALID}, 32'h0);
    end
    doFetch("stall", 32'h1111_000C, 32'hC);

    $display("[TB] decode backpressure");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 1'b1, 32'h2222_0010, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 1'b1, 32'h9999_9999, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("bp_valid", {31'h0, INSTR_VALID}, 32'h1);
      checkOutput("bp_instr", INSTR, 32'h2222_0010);
      checkOutput("bp_pc", INSTR_PC, 32'h10);
      checkOutput("bp_noreq", {31'h0, IMEM_REQ}, 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    checkOutput("bp_release_valid", {31'h0, INSTR_VALID}, 32'h0);
    checkOutput("bp_release_req", {31'h0, IMEM_REQ}, 32'h1);
    checkOutput("bp_release_addr", IMEM_ADDR, 32'h14);

    $display("[TB] redirect during wait");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
    step();
    checkOutput("brw_noreq", {31'h0, IMEM_REQ}, 32'h0);
    checkOutput("brw_addr", IMEM_ADDR, 32'h100);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    checkOutput("brw_still_wait", {31'h0, IMEM_REQ}, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    step();
    checkOutput("brw_dropped", {31'h0, INSTR_VALID}, 32'h0);
    checkOutput("brw_rereq", {31'h0, IMEM_REQ}, 32'h1);
    checkOutput("brw_target_addr", IMEM_ADDR, 32'h100);
    checkOutput("brw_instr_kept", INSTR, 32'h2222_0010);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    doFetch("brw_fetch", 32'h3333_0100, 32'h100);

    $display("[TB] redirect with rvalid and with consume");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 1'b1, 32'hBAD0_0104, 1'b0, 1'b1, 32'h0000_0200);
    step();
    checkOutput("brr_dropped", {31'h0, INSTR_VALID}, 32'h0);
    checkOutput("brr_rereq", {31'h0, IMEM_REQ}, 32'h1);
    checkOutput("brr_addr", IMEM_ADDR, 32'h200);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 1'b1, 32'hBAD0_0200, 1'b0, 1'b0, 32'h0);
    step();
    checkOutput("brh_valid", {31'h0, INSTR_VALID}, 32'h1);
    checkOutput("brh_pc", INSTR_PC, 32'h200);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0300);
    step();
    checkOutput("brh_squash", {31'h0, INSTR_VALID}, 32'h0);
    checkOutput("brh_rereq", {31'h0, IMEM_REQ}, 32'h1);
    checkOutput("brh_addr", IMEM_ADDR, 32'h300);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    doFetch("brh_fetch", 32'h4444_0300, 32'h300);

    $display("[TB] redirect in req without grant");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0042);
    step();
    checkOutput("brq_req", {31'h0, IMEM_REQ}, 32'h1);
    checkOutput("brq_addr", IMEM_ADDR, 32'h40);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    doFetch("brq_fetch", 32'h5555_0040, 32'h40);

    $display("[TB] wrapping reset vector");
    RESET_N = 1'b0;
    step();
    RESET_N = 1'b1;
    step();
    checkOutput("wrap_req", {31'h0, d1_imem_req}, 32'h1);
    checkOutput("wrap_addr", d1_imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0);
    step();
    checkOutput("wrap_valid", {31'h0, d1_instr_valid}, 32'h1);
    checkOutput("wrap_instr", d1_instr, 32'h0000_1234);
    checkOutput("wrap_instr_pc", d1_instr_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_r15", d1_r15, 32'h0000_0004);
    checkOutput("wrap_pc_next", d1_imem_addr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    checkOutput("wrap_rereq", {31'h0, d1_imem_req}, 32'h1);
    checkOutput("wrap_rereq_addr", d1_imem_addr, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    RESET_N = 1'b0;
    #2;
    checkOutput("async_req", {31'h0, d1_imem_req}, 32'h0);
    checkOutput("async_addr", d1_imem_addr, 32'hFFFF_FFFC);
    checkOutput("async_valid", {31'h0, d1_instr_valid}, 32'h0);
    checkOutput("async_instr", d1_instr, 32'h0);
    checkOutput("async_instr_pc", d1_instr_pc, 32'hFFFF_FFFC);
    checkOutput("async_r15", d1_r15, 32'h0000_0004);
    checkOutput("async_main_addr", IMEM_ADDR, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
